// File: rtl/fir_pin_driver.sv
// fir_pin_driver
//   Host-side initiator for the 8-pin FIR tile pin protocol. It sequences the
//   tile reset and coefficient load, then streams samples from a valid/ready
//   source onto the tile pins. Tile results come back on dut_out and are
//   captured into a small result FIFO with a valid/ready output.
//
//   Pin map of dut_in: [0] tile clock (driven 0, integrator wires clk there),
//                      [1] tile reset, [7:2] signed sample / coefficient.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   start                pulse: (re)run the tile reset + coefficient load
//   busy                 high while resetting / collecting / loading the tile
//   coef_valid/ready/data coefficient input handshake (signed BW_in)
//   s_valid/ready/data   sample input handshake (signed BW_in)
//   r_valid/ready/data   result output handshake (BW_out raw tile bits)
//   dut_in               tile input pins
//   dut_out              tile output pins, bits BW_out-1:0 used
//   mismatch             (FIRDRV_CHECK_EN only) sticky result-check flag
//
// Optional feature: define FIRDRV_CHECK_EN to add a single-tap reference
// model that compares every captured result against coef[0]*sample.

module fir_pin_driver #(
    parameter int N_TAPS         = 1,
    parameter int BW_in          = 6,
    parameter int BW_out         = 8,
    parameter int RESET_CYCLES   = 2,
    parameter int RESULT_LATENCY = 1,
    parameter int RES_DEPTH      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    input  logic              coef_valid,
    output logic              coef_ready,
    input  logic [BW_in-1:0]  coef_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [BW_in-1:0]  s_data,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [BW_out-1:0] r_data,
    output logic [7:0]        dut_in,
    input  logic [7:0]        dut_out
`ifdef FIRDRV_CHECK_EN
    ,
    output logic              mismatch
`endif
);

    localparam int          SR_LEN     = 1 + RESULT_LATENCY;
    localparam int          CNT_W      = $clog2(RES_DEPTH + 1);
    localparam int          IDX_W      = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam int          COEF_SLOTS = 1 << IDX_W;
    localparam int          RC_W       = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int unsigned DEPTH_U    = RES_DEPTH;
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RESET_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_TAPS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_COLLECT,
        ST_LOAD,
        ST_STREAM
    } state_t;

    state_t state, state_nx;

    logic [RC_W-1:0]   rst_cnt;
    logic [IDX_W-1:0]  coef_idx;
    logic [IDX_W-1:0]  load_idx;
    logic [BW_in-1:0]  coef_buf [COEF_SLOTS];

    // One bit per cycle of tile latency: a 1 marks a cycle whose tile result
    // must be captured when it reaches the end of the line.
    logic [SR_LEN-1:0] infl, infl_nx;
    int unsigned       infl_cnt;

    // Shift-down FIFO: entry 0 is always the head, so r_data is a register.
    logic [BW_out-1:0] fifo_mem [RES_DEPTH];
    logic [BW_out-1:0] mem_nx   [RES_DEPTH];
    logic [CNT_W-1:0]  fifo_cnt, cnt_nx;

    logic coef_acc, s_acc, push, pop;

    // ---------------- handshakes ----------------
    always_comb begin
        infl_cnt = 0;
        for (int unsigned i = 0; i < SR_LEN; i++) begin
            infl_cnt = infl_cnt + 32'(infl[i]);
        end
    end

    // start wins over any same-cycle handshake
    assign coef_ready = (state == ST_COLLECT) && !start;
    assign s_ready    = (state == ST_STREAM) && !start &&
                        ((32'(fifo_cnt) + infl_cnt) < DEPTH_U);
    assign r_valid    = (fifo_cnt != '0);
    assign r_data     = fifo_mem[0];

    assign coef_acc = coef_valid && coef_ready;
    assign s_acc    = s_valid && s_ready;
    assign push     = infl[SR_LEN-1];
    assign pop      = r_valid && r_ready;

    // ---------------- next state ----------------
    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = ST_RST;
        end else begin
            case (state)
                ST_IDLE:    state_nx = ST_IDLE;
                ST_RST:     if (rst_cnt == RC_LAST) state_nx = ST_COLLECT;
                ST_COLLECT: if (coef_acc && coef_idx == IDX_LAST) state_nx = ST_LOAD;
                ST_LOAD:    if (load_idx == IDX_LAST) state_nx = ST_STREAM;
                ST_STREAM:  state_nx = ST_STREAM;
                default:    state_nx = ST_IDLE;
            endcase
        end
    end

    // ---------------- in-flight line and FIFO next values ----------------
    always_comb begin
        infl_nx    = '0;
        infl_nx[0] = s_acc;
        for (int unsigned i = 1; i < SR_LEN; i++) begin
            infl_nx[i] = infl[i-1];
        end
    end

    // Pop shifts first, then the push lands at the post-pop count, so a
    // simultaneous push/pop on a single-entry FIFO writes the new head.
    always_comb begin
        mem_nx = fifo_mem;
        cnt_nx = fifo_cnt;
        if (pop) begin
            for (int unsigned i = 0; i + 1 < DEPTH_U; i++) begin
                mem_nx[i] = fifo_mem[i+1];
            end
            cnt_nx = cnt_nx - CNT_W'(1);
        end
        if (push) begin
            for (int unsigned i = 0; i < DEPTH_U; i++) begin
                if (i == 32'(cnt_nx)) mem_nx[i] = dut_out[BW_out-1:0];
            end
            cnt_nx = cnt_nx + CNT_W'(1);
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            dut_in   <= 8'h02;
            rst_cnt  <= '0;
            coef_idx <= '0;
            load_idx <= '0;
            infl     <= '0;
            fifo_cnt <= '0;
            for (int unsigned i = 0; i < COEF_SLOTS; i++) coef_buf[i] <= '0;
            for (int unsigned i = 0; i < DEPTH_U; i++)    fifo_mem[i] <= '0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == ST_RST) || (state_nx == ST_COLLECT) ||
                     (state_nx == ST_LOAD);
            if (start) begin
                dut_in   <= 8'h02;
                rst_cnt  <= '0;
                coef_idx <= '0;
                load_idx <= '0;
                infl     <= '0;
                fifo_cnt <= '0;
                for (int unsigned i = 0; i < COEF_SLOTS; i++) coef_buf[i] <= '0;
                for (int unsigned i = 0; i < DEPTH_U; i++)    fifo_mem[i] <= '0;
            end else begin
                infl     <= infl_nx;
                fifo_mem <= mem_nx;
                fifo_cnt <= cnt_nx;
                case (state)
                    ST_IDLE: dut_in <= 8'h02;
                    ST_RST: begin
                        dut_in  <= 8'h02;
                        rst_cnt <= rst_cnt + RC_W'(1);
                    end
                    ST_COLLECT: begin
                        if (coef_acc) begin
                            coef_buf[coef_idx] <= coef_data;
                            coef_idx           <= coef_idx + IDX_W'(1);
                        end
                    end
                    ST_LOAD: begin
                        // tile reset drops together with coef[0] on the pins
                        dut_in   <= 8'({coef_buf[load_idx], 2'b00});
                        load_idx <= load_idx + IDX_W'(1);
                    end
                    ST_STREAM: begin
                        if (s_acc) dut_in <= 8'({s_data, 2'b00});
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef FIRDRV_CHECK_EN
    generate
        if (N_TAPS == 1) begin : g_chk
            // Sample line runs parallel to infl so each captured result
            // meets the sample that produced it.
            logic [BW_in-1:0]         smp_line [SR_LEN];
            logic signed [BW_out-1:0] expect_lo;

            always_comb begin
                expect_lo = $signed(coef_buf[0]) * $signed(smp_line[SR_LEN-1]);
            end

            always_ff @(posedge clk) begin
                if (reset || start) begin
                    mismatch <= 1'b0;
                    for (int unsigned i = 0; i < SR_LEN; i++) smp_line[i] <= '0;
                end else begin
                    smp_line[0] <= s_data;
                    for (int unsigned i = 1; i < SR_LEN; i++) smp_line[i] <= smp_line[i-1];
                    if (push && (dut_out[BW_out-1:0] != expect_lo)) mismatch <= 1'b1;
                end
            end
        end else begin : g_nochk
            assign mismatch = 1'b0;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_fir_pin_driver.sv
// Self-checking bench for fir_pin_driver with a behavioural single-tap tile
// attached to the pins. Expected values are hand-computed constants.
module tb_fir_pin_driver;

    logic       clk = 1'b0;
    logic       reset, start, busy;
    logic       coef_valid, coef_ready;
    logic [5:0] coef_data, s_data;
    logic       s_valid, s_ready, r_valid, r_ready;
    logic [7:0] r_data, dut_in, dut_out;
`ifdef FIRDRV_CHECK_EN
    logic       mismatch;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_pin_driver #(
        .N_TAPS(1), .BW_in(6), .BW_out(8),
        .RESET_CYCLES(2), .RESULT_LATENCY(1), .RES_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
        .dut_in(dut_in), .dut_out(dut_out)
`ifdef FIRDRV_CHECK_EN
        ,
        .mismatch(mismatch)
`endif
    );

    // Tile model: reset pin clears it, first edge out of reset latches the
    // coefficient, later edges register coef*pins (one stage of latency).
    logic signed [5:0]  tile_coef;
    logic               tile_loaded;
    logic               force_bad = 1'b0;
    logic [7:0]         tile_out;
    logic signed [11:0] tile_prod;

    assign tile_prod = tile_coef * $signed(dut_in[7:2]);
    assign dut_out   = tile_out;

    always @(posedge clk) begin
        if (dut_in[1]) begin
            tile_loaded <= 1'b0;
            tile_out    <= 8'h00;
        end else if (!tile_loaded) begin
            tile_coef   <= dut_in[7:2];
            tile_loaded <= 1'b1;
        end else begin
            tile_out <= tile_prod[7:0] ^ {7'd0, force_bad};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called right after the start edge: two RST cycles, collect, load.
    task automatic load_coef(input logic [5:0] c);
        tick();
        tick();
        checks++; if (coef_ready !== 1'b1) begin errors++; $display("FAIL load_coef_ready got %b exp 1", coef_ready); end
        coef_valid = 1'b1;
        coef_data  = c;
        tick();
        coef_valid = 1'b0;
        tick();
        checks++; if (dut_in !== {c, 2'b00}) begin errors++; $display("FAIL load_coef_pins got %h exp %h", dut_in, {c, 2'b00}); end
    endtask

    task automatic test_reset();
        checks++; if (dut_in !== 8'h02) begin errors++; $display("FAIL reset_dut_in got %h exp 02", dut_in); end
        checks++; if (coef_ready !== 1'b0) begin errors++; $display("FAIL reset_coef_ready got %b exp 0", coef_ready); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b exp 0", s_ready); end
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL reset_r_valid got %b exp 0", r_valid); end
        checks++; if (r_data !== 8'h00) begin errors++; $display("FAIL reset_r_data got %h exp 00", r_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        reset = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || dut_in !== 8'h02) begin errors++; $display("FAIL idle_hold got busy=%b dut_in=%h exp busy=0 dut_in=02", busy, dut_in); end
    endtask

    task automatic test_start_load();
        do_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst1_busy got %b exp 1", busy); end
        checks++; if (coef_ready !== 1'b0 || dut_in !== 8'h02) begin errors++; $display("FAIL rst1 got ready=%b dut_in=%h exp 0/02", coef_ready, dut_in); end
        tick();
        checks++; if (coef_ready !== 1'b0 || dut_in !== 8'h02) begin errors++; $display("FAIL rst2 got ready=%b dut_in=%h exp 0/02", coef_ready, dut_in); end
        tick();
        checks++; if (coef_ready !== 1'b1 || busy !== 1'b1 || dut_in !== 8'h02) begin errors++; $display("FAIL collect got ready=%b busy=%b dut_in=%h exp 1/1/02", coef_ready, busy, dut_in); end
        coef_valid = 1'b1;
        coef_data  = 6'd3;
        tick();
        coef_valid = 1'b0;
        checks++; if (coef_ready !== 1'b0 || dut_in !== 8'h02) begin errors++; $display("FAIL load_enter got ready=%b dut_in=%h exp 0/02", coef_ready, dut_in); end
        tick();
        checks++; if (dut_in !== 8'h0C) begin errors++; $display("FAIL load_pins got %h exp 0c", dut_in); end
        checks++; if (busy !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("FAIL stream_enter got busy=%b s_ready=%b exp 0/1", busy, s_ready); end
    endtask

    task automatic test_back_to_back();
        r_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 6'd5;
        tick();
        checks++; if (dut_in !== 8'h14 || r_valid !== 1'b0) begin errors++; $display("FAIL b2b_a1 got dut_in=%h r_valid=%b exp 14/0", dut_in, r_valid); end
        s_data = 6'h3E;
        tick();
        checks++; if (dut_in !== 8'hF8 || r_valid !== 1'b0) begin errors++; $display("FAIL b2b_a2 got dut_in=%h r_valid=%b exp f8/0", dut_in, r_valid); end
        s_valid = 1'b0;
        tick();
        checks++; if (r_valid !== 1'b1 || r_data !== 8'h0F) begin errors++; $display("FAIL b2b_r1 got v=%b d=%h exp 1/0f", r_valid, r_data); end
        tick();
        checks++; if (r_valid !== 1'b1 || r_data !== 8'hFA) begin errors++; $display("FAIL b2b_r2 got v=%b d=%h exp 1/fa", r_valid, r_data); end
        tick();
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", r_valid); end
    endtask

    task automatic test_backpressure();
        logic [7:0] e;
        do_start();
        load_coef(6'h3F);
        r_ready = 1'b0;
        s_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            s_data = (k < 4) ? 6'(k + 1) : 6'd4;
            checks++; if (s_ready !== (k < 4)) begin errors++; $display("FAIL bp_ready k=%0d got %b exp %b", k, s_ready, (k < 4)); end
            tick();
        end
        checks++; if (r_valid !== 1'b1 || r_data !== 8'hFF) begin errors++; $display("FAIL bp_full got v=%b d=%h exp 1/ff", r_valid, r_data); end
        tick();
        checks++; if (r_valid !== 1'b1 || r_data !== 8'hFF) begin errors++; $display("FAIL bp_hold got v=%b d=%h exp 1/ff", r_valid, r_data); end
        s_valid = 1'b0;
        r_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e = 8'(0 - (i + 1));
            checks++; if (r_valid !== 1'b1 || r_data !== e) begin errors++; $display("FAIL bp_drain i=%0d got v=%b d=%h exp 1/%h", i, r_valid, r_data, e); end
            tick();
        end
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", r_valid); end
        tick();
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL bp_nodup got %b exp 0", r_valid); end
    endtask

    task automatic test_gap();
        r_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 6'd6;
        tick();
        s_valid = 1'b0;
        checks++; if (dut_in !== 8'h18) begin errors++; $display("FAIL gap_a1 got %h exp 18", dut_in); end
        tick();
        checks++; if (dut_in !== 8'h18 || r_valid !== 1'b0) begin errors++; $display("FAIL gap_hold got dut_in=%h v=%b exp 18/0", dut_in, r_valid); end
        tick();
        checks++; if (r_valid !== 1'b1 || r_data !== 8'hFA) begin errors++; $display("FAIL gap_r1 got v=%b d=%h exp 1/fa", r_valid, r_data); end
        tick();
        checks++; if (r_valid !== 1'b0 || dut_in !== 8'h18) begin errors++; $display("FAIL gap_noextra got v=%b dut_in=%h exp 0/18", r_valid, dut_in); end
        s_valid = 1'b1;
        s_data  = 6'h3D;
        tick();
        s_valid = 1'b0;
        checks++; if (dut_in !== 8'hF4 || r_valid !== 1'b0) begin errors++; $display("FAIL gap_a2 got dut_in=%h v=%b exp f4/0", dut_in, r_valid); end
        tick();
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL gap_wait got %b exp 0", r_valid); end
        tick();
        checks++; if (r_valid !== 1'b1 || r_data !== 8'h03) begin errors++; $display("FAIL gap_r2 got v=%b d=%h exp 1/03", r_valid, r_data); end
        tick();
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL gap_end got %b exp 0", r_valid); end
    endtask

    task automatic test_start_flush();
        r_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 6'd2;
        tick();
        s_data = 6'd4;
        tick();
        s_valid = 1'b0;
        tick();
        tick();
        checks++; if (r_valid !== 1'b1 || r_data !== 8'hFE) begin errors++; $display("FAIL flush_pending got v=%b d=%h exp 1/fe", r_valid, r_data); end
        s_valid = 1'b1;
        start   = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL start_prio got %b exp 0", s_ready); end
        tick();
        start   = 1'b0;
        s_valid = 1'b0;
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL flush_r_valid got %b exp 0", r_valid); end
        checks++; if (dut_in !== 8'h02 || busy !== 1'b1) begin errors++; $display("FAIL flush_pins got dut_in=%h busy=%b exp 02/1", dut_in, busy); end
        load_coef(6'd3);
        r_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 6'd5;
        tick();
        s_valid = 1'b0;
        tick();
        tick();
        checks++; if (r_valid !== 1'b1 || r_data !== 8'h0F) begin errors++; $display("FAIL reload_r got v=%b d=%h exp 1/0f", r_valid, r_data); end
        tick();
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL reload_drain got %b exp 0", r_valid); end
    endtask

    task automatic test_reset_mid();
        s_valid = 1'b1;
        s_data  = 6'd7;
        tick();
        s_valid = 1'b0;
        reset   = 1'b1;
        tick();
        checks++; if (dut_in !== 8'h02 || busy !== 1'b0 || r_valid !== 1'b0 || r_data !== 8'h00) begin errors++; $display("FAIL midreset got dut_in=%h busy=%b v=%b d=%h exp 02/0/0/00", dut_in, busy, r_valid, r_data); end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (r_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_quiet i=%0d got v=%b busy=%b exp 0/0", i, r_valid, busy); end
        end
    endtask

`ifdef FIRDRV_CHECK_EN
    task automatic test_mismatch();
        do_start();
        load_coef(6'd3);
        r_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 6'd5;
        tick();
        s_valid = 1'b0;
        tick();
        tick();
        checks++; if (r_data !== 8'h0F || mismatch !== 1'b0) begin errors++; $display("FAIL chk_good got d=%h mm=%b exp 0f/0", r_data, mismatch); end
        tick();
        s_valid = 1'b1;
        s_data  = 6'd1;
        tick();
        s_valid   = 1'b0;
        force_bad = 1'b1;
        tick();
        force_bad = 1'b0;
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL chk_early got %b exp 0", mismatch); end
        tick();
        checks++; if (mismatch !== 1'b1 || r_data !== 8'h02) begin errors++; $display("FAIL chk_set got mm=%b d=%h exp 1/02", mismatch, r_data); end
        tick();
        checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL chk_sticky got %b exp 1", mismatch); end
        do_start();
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL chk_clear got %b exp 0", mismatch); end
    endtask
`endif

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        coef_valid = 1'b0;
        coef_data  = '0;
        s_valid    = 1'b0;
        s_data     = '0;
        r_ready    = 1'b0;
        tick();
        tick();
        test_reset();
        test_start_load();
        test_back_to_back();
        test_backpressure();
        test_gap();
        test_start_flush();
        test_reset_mid();
`ifdef FIRDRV_CHECK_EN
        test_mismatch();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
